// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Radix-2 restoring division; drives the controller's pause/unpause.
module div_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            pause_signal,
  output logic            unpause_signal,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic [4:0]      result_rd
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, nstate;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] den;
  logic [XLEN:0]   rem;
  logic            qsign;
  logic            rsign;
  logic            rem_sel;
  logic [4:0]      rd_q;

  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;
  logic            start_ok;
  logic            last;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            qbit;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin;

  assign sgn      = ~op[0];
  assign a_neg    = sgn & dividend[XLEN-1];
  assign b_neg    = sgn & divisor[XLEN-1];
  assign a_abs    = a_neg ? -dividend : dividend;
  assign b_abs    = b_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = sgn
                  & (dividend == {1'b1, {(XLEN-1){1'b0}}})
                  & (divisor == '1);
  assign special  = div_zero | ovf;
  assign start_ok = (state == IDLE) & start & ~flush;
  assign last     = (cnt == CW'(ITER - 1));

  // Overflow: quotient is INT_MIN, remainder 0.
  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      op[1] & div_zero:  spec_res = dividend;
      op[1] & ~div_zero: spec_res = '0;
      ~op[1] & div_zero: spec_res = '1;
      default:           spec_res = {1'b1, {(XLEN-1){1'b0}}};
    endcase
  end

  assign rem_sh = {rem[XLEN-1:0], quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, den};
  assign qbit   = ~diff[XLEN];
  assign rem_nx = qbit ? diff : rem_sh;
  assign quo_nx = {quo[XLEN-2:0], qbit};
  assign q_fix  = qsign ? -quo_nx : quo_nx;
  assign r_fix  = rsign ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
  assign fin    = rem_sel ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      quo       <= '0;
      den       <= '0;
      rem       <= '0;
      qsign     <= 1'b0;
      rsign     <= 1'b0;
      rem_sel   <= 1'b0;
      rd_q      <= '0;
      result    <= '0;
      result_rd <= '0;
    end else begin
      state <= nstate;
      if (start_ok) begin
        rem_sel <= op[1];
        rd_q    <= rd_in;
        quo     <= a_abs;
        den     <= b_abs;
        rem     <= '0;
        cnt     <= '0;
        qsign   <= a_neg ^ b_neg;
        rsign   <= a_neg;
        if (special) begin
          result    <= spec_res;
          result_rd <= rd_in;
        end
      end else if (state == CALC && !flush) begin
        quo <= quo_nx;
        rem <= rem_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          result    <= fin;
          result_rd <= rd_q;
        end
      end
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start_ok) nstate = special ? DONE : CALC;
      CALC: begin
        if (flush)     nstate = IDLE;
        else if (last) nstate = DONE;
      end
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // A flush while busy must still release the controller.
  always_comb begin
    busy           = (state != IDLE);
    unpause_signal = (state == DONE) | (flush & (state != IDLE));
    result_valid   = (state == DONE) & ~flush;
    pause_signal   = (start_ok | (state == CALC)) & ~unpause_signal;
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: reference model, latency,
// pause/unpause handshake, flush and reset behaviour.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_in;
  logic        flush;
  logic        pause_signal;
  logic        unpause_signal;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic [4:0]  result_rd;

  int checks = 0;
  int failures = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  div_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op             (op),
    .dividend       (dividend),
    .divisor        (divisor),
    .rd_in          (rd_in),
    .flush          (flush),
    .pause_signal   (pause_signal),
    .unpause_signal (unpause_signal),
    .busy           (busy),
    .result         (result),
    .result_valid   (result_valid),
    .result_rd      (result_rd)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb_;
    logic ov;
    sa = a;
    sb_ = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'b00: model = (b == 0) ? 32'hFFFF_FFFF :
                     ov ? 32'h8000_0000 : 32'(sa / sb_);
      2'b01: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: model = (b == 0) ? a : ov ? 32'h0 : 32'(sa % sb_);
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("result", result, e[31:0]);
        chk("result_rd", result_rd, e[36:32]);
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r);
    int n;
    int bad;
    int lat;
    lat = ((b == 0) || (!o[0] && a == 32'h8000_0000 &&
           b == 32'hFFFF_FFFF)) ? 1 : 33;
    sb.push_back({r, model(o, a, b)});
    start = 1'b1;
    op = o;
    dividend = a;
    divisor = b;
    rd_in = r;
    #1;
    chk("pause_t0", pause_signal, 1);
    cyc();
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    n = 1;
    bad = 0;
    while (!result_valid && n < 60) begin
      if (!pause_signal || !busy) bad++;
      cyc();
      n++;
    end
    if (!result_valid) begin
      chk("timeout", 0, 1);
    end else begin
      chk("latency", n, lat);
      chk("pause_calc", bad, 0);
      chk("unpause_done", unpause_signal, 1);
      chk("pause_done", pause_signal, 0);
    end
    cyc();
    chk("busy_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    dividend = '0;
    divisor = '0;
    rd_in = '0;
    flush = 1'b0;
    cyc();
    cyc();
    chk("rst_outs", {pause_signal, unpause_signal, busy, result_valid}, 0);
    chk("rst_result", {result_rd, result}, 0);
    rst = 1'b0;
    cyc();

    run_op(2'b01, 32'd100, 32'd7, 5'd3);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(2'b00, 32'd5, 32'd0, 5'd6);
    run_op(2'b11, 32'd5, 32'd0, 5'd7);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd10);
    run_op(2'b00, 32'h8000_0000, 32'd1, 5'd11);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] rb;
      rb = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      if (i % 3 == 0) rb = -rb;
      run_op(2'($urandom_range(0, 3)), $urandom, rb, 5'(i + 12));
    end

    // Flush on the 10th CALC cycle
    start = 1'b1;
    op = 2'b01;
    dividend = 32'd1000;
    divisor = 32'd3;
    rd_in = 5'd1;
    cyc();
    start = 1'b0;
    for (int i = 1; i < 10; i++) cyc();
    flush = 1'b1;
    #1;
    chk("flush_unpause", unpause_signal, 1);
    chk("flush_pause", pause_signal, 0);
    chk("flush_valid", result_valid, 0);
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_idle", busy, 0);
    cyc();
    run_op(2'b01, 32'd1000, 32'd3, 5'd2);

    // Flush in IDLE blocks start
    flush = 1'b1;
    start = 1'b1;
    #1;
    chk("flush_idle_pause", pause_signal, 0);
    cyc();
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_idle_busy", busy, 0);

    // Reset on the 5th CALC cycle with start held high
    start = 1'b1;
    op = 2'b00;
    dividend = 32'd77;
    divisor = 32'd5;
    rd_in = 5'd30;
    cyc();
    for (int i = 1; i < 5; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("rst_mid_outs",
        {pause_signal, unpause_signal, busy, result_valid}, 0);
    chk("rst_mid_result", {result_rd, result}, 0);
    for (int i = 0; i < 40; i++) cyc();
    chk("rst_mid_quiet", busy, 0);

    run_op(2'b10, 32'd77, 32'hFFFF_FFFB, 5'd31);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divider in the EX stage. Executes DIV, DIVU, REM and REMU.
- Is the producer of the pipeline controller's `pause_signal` and `unpause_signal` inputs:
  - raises `pause_signal` while a division is in flight;
  - pulses `unpause_signal` when the result is ready or the operation is aborted.
- Consumes the controller's `flush` output to abort in-flight work.

Parameters:
- XLEN, 32, operand/result width.
- ITER, 32, radix-2 iterations per division; must equal XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (equals funct3[1:0]).
- dividend  input  XLEN  rs1 value, sampled with start.
- divisor  input  XLEN  rs2 value, sampled with start.
- rd_in  input  5  destination register, sampled with start.
- flush  input  1  abort request from pipeline controller.
- pause_signal  output  1  to controller: hold pipeline.
- unpause_signal  output  1  to controller: release pipeline (1-cycle pulse).
- busy  output  1  unit not in IDLE.
- result  output  XLEN  quotient or remainder.
- result_valid  output  1  result/result_rd valid this cycle (1-cycle pulse).
- result_rd  output  5  destination register of result.

Behaviour:
- Reset (clk edge with rst=1) overrides all other inputs:
  - state=IDLE; counter, operand and partial-remainder registers cleared.
  - result=0, result_rd=0.
  - All 1-bit outputs 0 while in IDLE with start=0.
  - Reset mid-division discards the operation with no unpause pulse; the controller is reset by the same rst.
- State machine IDLE / CALC / DONE:
  - IDLE, start=1, flush=0:
    - latch op, rd_in, |dividend|, |divisor| (abs only for signed ops), quotient sign = sign(a)^sign(b), remainder sign = sign(a).
    - Special cases (divisor=0, or signed op with dividend=0x80000000 and divisor=0xFFFFFFFF) go straight to DONE.
    - Otherwise go to CALC with counter=0.
  - CALC: one restoring-division step per cycle on a 33-bit partial remainder. Counter increments; at counter=ITER-1 the next state is DONE.
  - DONE: one cycle only, then IDLE.
    - result_valid=1, unpause_signal=1, pause_signal=0.
    - result is registered, applying sign correction for DIV/REM.
- Latency with start at cycle T:
  - normal: CALC occupies T+1..T+32; DONE, result_valid and unpause are in T+33.
  - special case: DONE in T+1.
- pause_signal (combinational):
  - = (state==IDLE && start && !flush) || state==CALC;
  - forced 0 in any cycle where unpause_signal=1.
- Special-case results (RISC-V spec):
  - divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
  - overflow: quotient=0x80000000, remainder=0.
- Sign correction: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set. Unsigned ops skip correction.
- Flush:
  - flush=1 while state is CALC or DONE: next state IDLE, result_valid=0 that cycle and after. unpause_signal=1 and pause_signal=0 combinationally in the flush cycle, so the controller releases.
  - flush=1 in IDLE: start is ignored, no pause is raised.
- start while busy: ignored; operands are not re-sampled.
- result and result_rd hold their last values after DONE until the next DONE.
- busy = state != IDLE.

Test Plan:
- DIVU 100/7, start at T → pause_signal high T..T+32; result=14, result_rd=rd_in, result_valid=unpause_signal=1, pause_signal=0 exactly in T+33; busy low in T+34.
- REM dividend=-7 (0xFFFFFFF9), divisor=2 → result=0xFFFFFFFF at T+33; DIV same operands → 0xFFFFFFFD (-3).
- DIV 5/0 → result=0xFFFFFFFF at T+1; REMU 5/0 → result=5 at T+1; no CALC cycles.
- DIV 0x80000000 / 0xFFFFFFFF → result=0x80000000 at T+1; REM same → 0.
- Flush at the 10th CALC cycle → unpause_signal=1 and pause_signal=0 that cycle; IDLE next cycle; no result_valid; a start issued 2 cycles later completes normally with correct result.
- Reset asserted at 5th CALC cycle → next cycle all outputs 0 and state IDLE; a start held high during the rst cycle is ignored.
